frame_stream_writer: RTL and testbench

- Parametrised successor to the ethernet-side frame packaging stage.
- Consumes the firewall's filtered 2-bit dibit stream directly. Parses a per-packet start-address header, then assembles PIXEL_W-bit pixels and emits write strobes to the frame buffer's 50 MHz port at auto-incrementing addresses.
- Adds what the previous stage lacks: bounds checking, drop accounting, end-of-frame detection, and optional double buffering with bank swap.

---
 rtl/frame_stream_writer.sv | 151 +++++++++++++++
 tb/tb_frame_stream_writer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/frame_stream_writer.sv
// frame_stream_writer: dibit stream to frame buffer writes with header address, bounds check and bank swap
module frame_stream_writer #(
    parameter int PIXEL_W       = 8,
    parameter int FRAME_W       = 320,
    parameter int FRAME_H       = 240,
    parameter int ADDR_W        = 17,
    parameter int HDR_W         = 24,
    parameter int DOUBLE_BUFFER = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               axiiv,
    input  logic [1:0]         axiid,
    output logic               axiov,
    output logic [ADDR_W-1:0]  addr_axiod,
    output logic [PIXEL_W-1:0] pixel_axiod,
    output logic               bank_axiod,
    output logic               display_bank,
    output logic               frame_done,
    output logic [15:0]        drop_count,
    output logic               oob
);
    localparam int DEPTH = FRAME_W * FRAME_H;
    localparam int HN = HDR_W / 2;
    localparam int PN = PIXEL_W / 2;
    localparam int CW = $clog2(HN + 1);
    localparam int PW = $clog2(PN + 1);
    localparam logic [ADDR_W:0] DEP  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DRAIN} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [ADDR_W-1:0] hdr_q, hdr_d, hdr_n, addr_q, addr_d;
    logic [PIXEL_W-1:0] pix_q, pix_d, pix_n, pout_q, pout_d;
    logic [ADDR_W:0] wr_q, wr_d;
    logic [15:0] drop_q, drop_d, drop_inc;
    logic axiov_q, axiov_d, bout_q, bout_d, done_q, done_d, oob_q, oob_d, bank_q, bank_d, in_range;
    // next-state: header parse, pixel assembly, bounds check, accounting and bank toggle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pcnt_d   = pcnt_q;
        hdr_d    = hdr_q;
        pix_d    = pix_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        pout_d   = pout_q;
        bout_d   = bout_q;
        drop_d   = drop_q;
        oob_d    = oob_q;
        bank_d   = bank_q;
        axiov_d  = 1'b0;
        done_d   = 1'b0;
        hdr_n    = ADDR_W'({hdr_q, axiid});
        pix_n    = PIXEL_W'({pix_q, axiid});
        in_range = wr_q < DEP;
        drop_inc = (&drop_q) ? drop_q : drop_q + 16'd1;
        case (state_q)
            IDLE: begin
                pcnt_d = '0;
                if (axiiv) begin
                    hdr_d   = hdr_n;
                    cnt_d   = CW'(1);
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (!axiiv) begin
                    drop_d  = drop_inc;
                    state_d = IDLE;
                end else begin
                    hdr_d = hdr_n;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(HN - 1)) begin
                        state_d = ({1'b0, hdr_n} < DEP) ? PAYLOAD : DRAIN;
                        drop_d  = ({1'b0, hdr_n} < DEP) ? drop_q : drop_inc;
                        wr_d    = {1'b0, hdr_n};
                        pcnt_d  = '0;
                    end
                end
            end
            PAYLOAD: begin
                if (!axiiv) begin
                    state_d = IDLE;
                    pcnt_d  = '0;
                end else begin
                    pix_d  = pix_n;
                    pcnt_d = pcnt_q + PW'(1);
                    if (pcnt_q == PW'(PN - 1)) begin
                        pcnt_d = '0;
                        wr_d   = in_range ? wr_q + 1'b1 : wr_q;
                        oob_d  = oob_q | ~in_range;
                        if (in_range) begin
                            axiov_d = 1'b1;
                            addr_d  = wr_q[ADDR_W-1:0];
                            pout_d  = pix_n;
                            bout_d  = bank_q;
                            done_d  = wr_q == LAST;
                            bank_d  = bank_q ^ (done_d & (DOUBLE_BUFFER != 0));
                        end
                    end
                end
            end
            DRAIN: state_d = axiiv ? DRAIN : IDLE;
            default: state_d = IDLE;
        endcase
    end
    // state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pcnt_q  <= '0;
            hdr_q   <= '0;
            pix_q   <= '0;
            wr_q    <= '0;
            addr_q  <= '0;
            pout_q  <= '0;
            bout_q  <= 1'b0;
            drop_q  <= '0;
            oob_q   <= 1'b0;
            bank_q  <= 1'b0;
            axiov_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            hdr_q   <= hdr_d;
            pix_q   <= pix_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            pout_q  <= pout_d;
            bout_q  <= bout_d;
            drop_q  <= drop_d;
            oob_q   <= oob_d;
            bank_q  <= bank_d;
            axiov_q <= axiov_d;
            done_q  <= done_d;
        end
    end
    assign axiov        = axiov_q;
    assign addr_axiod   = addr_q;
    assign pixel_axiod  = pout_q;
    assign bank_axiod   = bout_q;
    assign frame_done   = done_q;
    assign drop_count   = drop_q;
    assign oob          = oob_q;
    assign display_bank = (DOUBLE_BUFFER != 0) & ~bank_q;
endmodule

// File: tb/tb_frame_stream_writer.sv
// tb_frame_stream_writer: directed and random packets checked against a packet-level model
module tb_frame_stream_writer;
    localparam int PW = 8, FW = 320, FH = 240, AW = 17, HW = 24;
    localparam int DEPTH = FW * FH, HN = HW / 2, PD = PW / 2;
    logic clk = 1'b0, rst = 1'b1, axiiv = 1'b0;
    logic [1:0] axiid = 2'd0;
    logic axiov, bank_axiod, display_bank, frame_done, oob;
    logic [AW-1:0] addr_axiod;
    logic [PW-1:0] pixel_axiod;
    logic [15:0] drop_count;
    frame_stream_writer #(.PIXEL_W(PW), .FRAME_W(FW), .FRAME_H(FH), .ADDR_W(AW), .HDR_W(HW), .DOUBLE_BUFFER(1)) dut (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .axiov(axiov),
        .addr_axiod(addr_axiod), .pixel_axiod(pixel_axiod), .bank_axiod(bank_axiod),
        .display_bank(display_bank), .frame_done(frame_done), .drop_count(drop_count), .oob(oob)
    );
    always #10 clk = ~clk;
    int checks = 0, errors = 0;
    task automatic chk(input string n, input longint a, input longint e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", n, a, e, $time);
        end
    endtask
    // packet-level model: dibit index within the packet decides header, pixel boundaries and addresses
    bit m_axiov, m_done, m_oob, m_disp, m_bout, m_bank, ok;
    int m_addr, m_pix, m_drop, n, start, p, pv, a;
    logic [23:0] hv;
    always @(posedge clk) begin
        if (rst) begin
            m_axiov = 0; m_done = 0; m_oob = 0; m_disp = 1; m_bout = 0; m_bank = 0;
            m_addr = 0; m_pix = 0; m_drop = 0; n = 0; hv = 0; pv = 0; ok = 0;
        end else begin
            m_axiov = 0;
            m_done = 0;
            if (axiiv) begin
                n++;
                if (n <= HN) begin
                    hv = {hv[21:0], axiid};
                    if (n == HN) begin
                        start = int'(hv[AW-1:0]);
                        ok = start < DEPTH;
                        p = 0;
                        pv = 0;
                        if (!ok && m_drop < 65535) m_drop++;
                    end
                end else if (ok) begin
                    pv = ((pv << 2) | int'(axiid)) & ((1 << PW) - 1);
                    if ((n - HN) % PD == 0) begin
                        a = start + p;
                        p++;
                        if (a < DEPTH) begin
                            m_axiov = 1; m_addr = a; m_pix = pv; m_bout = m_bank;
                            if (a == DEPTH - 1) begin
                                m_done = 1;
                                m_disp = m_bank;
                                m_bank = ~m_bank;
                            end
                        end else m_oob = 1;
                    end
                end
            end else begin
                if (n > 0 && n < HN && m_drop < 65535) m_drop++;
                n = 0;
            end
        end
    end
    int qa[$], qd[$], qb[$], qf[$];
    // per-cycle comparison against the model plus a log of DUT writes
    always @(negedge clk) begin
        chk("axiov", axiov, m_axiov);
        chk("frame_done", frame_done, m_done);
        chk("drop_count", drop_count, m_drop);
        chk("oob", oob, m_oob);
        chk("display_bank", display_bank, m_disp);
        if (m_axiov) begin
            chk("addr", addr_axiod, m_addr);
            chk("pixel", pixel_axiod, m_pix);
            chk("bank", bank_axiod, m_bout);
        end
        if (axiov === 1'b1) begin
            qa.push_back(int'(addr_axiod));
            qd.push_back(int'(pixel_axiod));
            qb.push_back(int'(bank_axiod));
            qf.push_back(int'(frame_done));
        end
    end
    task automatic send_dibit(input logic [1:0] d);
        @(posedge clk); #2;
        axiiv = 1'b1;
        axiid = d;
    endtask
    task automatic gap(input int c);
        repeat (c) begin
            @(posedge clk); #2;
            axiiv = 1'b0;
            axiid = 2'd0;
        end
    endtask
    task automatic hdr(input logic [23:0] h);
        for (int i = HN - 1; i >= 0; i--) send_dibit(h[2*i +: 2]);
    endtask
    task automatic pix(input logic [7:0] v);
        for (int i = PD - 1; i >= 0; i--) send_dibit(v[2*i +: 2]);
    endtask
    task automatic clr();
        qa.delete(); qd.delete(); qb.delete(); qf.delete();
    endtask
    task automatic expw(input int i, input int ea, input int ed, input int eb, input int ef);
        chk("log_addr", qa[i], ea);
        chk("log_data", qd[i], ed);
        chk("log_bank", qb[i], eb);
        chk("log_done", qf[i], ef);
    endtask
    logic [23:0] h;
    int c;
    initial begin
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        chk("rst_axiov", axiov, 0);
        chk("rst_addr", addr_axiod, 0);
        chk("rst_disp", display_bank, 1);
        chk("rst_drop", drop_count, 0);
        clr();
        hdr(24'd0); pix(8'hA5); pix(8'h3C); pix(8'hFF); gap(3);
        chk("t1_n", qa.size(), 3);
        expw(0, 0, 'hA5, 0, 0); expw(1, 1, 'h3C, 0, 0); expw(2, 2, 'hFF, 0, 0);
        clr();
        hdr(24'd76799); pix(8'h11); gap(3);
        chk("t2_n", qa.size(), 1);
        expw(0, 76799, 'h11, 0, 1);
        chk("t2_disp", display_bank, 0);
        clr();
        hdr(24'd0); pix(8'h22); gap(3);
        expw(0, 0, 'h22, 1, 0);
        clr();
        hdr(24'd76798); pix(8'h01); pix(8'h02); pix(8'h03); gap(3);
        chk("t3_n", qa.size(), 2);
        expw(0, 76798, 1, 1, 0); expw(1, 76799, 2, 1, 1);
        chk("t3_oob", oob, 1);
        chk("t3_disp", display_bank, 1);
        clr();
        repeat (5) send_dibit(2'($urandom)); gap(2);
        chk("t4_drop", drop_count, 1);
        hdr(24'd5); pix(8'h77); gap(3);
        chk("t4_n", qa.size(), 1);
        expw(0, 5, 'h77, 0, 0);
        chk("t4_oob", oob, 1);
        clr();
        hdr(24'd80000); repeat (40) send_dibit(2'($urandom)); gap(2);
        chk("t5_n", qa.size(), 0);
        chk("t5_drop", drop_count, 2);
        hdr(24'd0); pix(8'h9C); repeat (3) send_dibit(2'($urandom)); gap(3);
        chk("t5b_n", qa.size(), 1);
        expw(0, 0, 'h9C, 0, 0);
        chk("t5b_drop", drop_count, 2);
        clr();
        hdr(24'd0); send_dibit(2'd1); send_dibit(2'd2);
        @(posedge clk); #2 rst = 1'b1; axiiv = 1'b0;
        @(posedge clk); #2 rst = 1'b0;
        chk("t6_drop", drop_count, 0);
        chk("t6_oob", oob, 0);
        chk("t6_disp", display_bank, 1);
        chk("t6_axiov", axiov, 0);
        hdr(24'd10); pix(8'h5A); gap(3);
        chk("t6_n", qa.size(), 1);
        expw(0, 10, 'h5A, 0, 0);
        repeat (200) begin
            c = $urandom_range(0, 4);
            case (c)
                0: h = 24'($urandom_range(0, DEPTH - 1));
                1: h = 24'(DEPTH - 1 - $urandom_range(0, 5));
                2: h = 24'(DEPTH + $urandom_range(0, 2000));
                3: h = {7'($urandom), 17'($urandom_range(0, DEPTH - 1))};
                default: h = 24'd0;
            endcase
            if (c == 4) repeat ($urandom_range(1, HN - 1)) send_dibit(2'($urandom));
            else begin
                hdr(h);
                repeat ($urandom_range(0, 40)) send_dibit(2'($urandom));
            end
            gap($urandom_range(1, 3));
        end
        gap(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
